// File: rtl/dfctrl_pkg.sv
// Shared dataflow-control types: activation-memory requester IDs and helpers.
package dfctrl_pkg;

  typedef enum logic [1:0] {
    REQ_SPI     = 2'd0,
    REQ_CORE_RD = 2'd1,
    REQ_CORE_WR = 2'd2
  } act_req_e;

  localparam logic [1:0] ACT_MEM_HEADER = 2'b10;
  localparam int         NUM_REQ        = 3;

  function automatic act_req_e onehot_to_req(input logic [2:0] oh);
    unique case (oh)
      3'b010:  return REQ_CORE_RD;
      3'b100:  return REQ_CORE_WR;
      default: return REQ_SPI;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin: search starts one past last_grant, wraps 2->0.
// Zero latency; no grant when nothing is eligible.
module rr_arbiter3
  import dfctrl_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] last_grant,
  output logic [2:0] grant
);

  logic [1:0] start;
  logic [2:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    start = (last_grant >= 2'd2) ? 2'd0 : last_grant + 2'd1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, start} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && elig[cand[1:0]]) begin
        grant[cand[1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/act_mem_arbiter.sv
// Round-robin share of the activation SRAM (SPI write, core read, core write); ACT_ARB_BOUNDS_CHECK_EN adds range checking.
// Command 1 cycle after accept, read data 2 cycles after; ready is high only for the granted requester.
module act_mem_arbiter
  import dfctrl_pkg::*;
#(
  parameter int WIDTH_ADDR_ACT = 12,
  parameter int WIDTH_ACT_MEM  = 8,
  parameter int DEPTH_ACT_MEM  = 3000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      compute_active,
  input  logic                      spi_wr_valid,
  output logic                      spi_wr_ready,
  input  logic [WIDTH_ADDR_ACT-1:0] spi_wr_addr,
  input  logic [WIDTH_ACT_MEM-1:0]  spi_wr_data,
  input  logic                      core_rd_valid,
  output logic                      core_rd_ready,
  input  logic [WIDTH_ADDR_ACT-1:0] core_rd_addr,
  output logic [WIDTH_ACT_MEM-1:0]  core_rd_data,
  output logic                      core_rd_data_valid,
  input  logic                      core_wr_valid,
  output logic                      core_wr_ready,
  input  logic [WIDTH_ADDR_ACT-1:0] core_wr_addr,
  input  logic [WIDTH_ACT_MEM-1:0]  core_wr_data,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [WIDTH_ADDR_ACT-1:0] mem_addr,
  output logic [WIDTH_ACT_MEM-1:0]  mem_wdata,
  input  logic [WIDTH_ACT_MEM-1:0]  mem_rdata,
  output logic [WIDTH_ADDR_ACT-1:0] host_wr_count,
  output logic                      err_oob
);

`ifdef ACT_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [2:0]                elig;
  logic [2:0]                grant;
  logic [1:0]                last_grant;
  logic                      xfer;
  act_req_e                  sel_req;
  logic                      sel_we;
  logic                      sel_oob;
  logic [WIDTH_ADDR_ACT-1:0] sel_addr;
  logic [WIDTH_ACT_MEM-1:0]  sel_wdata;

  logic                      mem_en_q;
  logic                      mem_we_q;
  logic [WIDTH_ADDR_ACT-1:0] mem_addr_q;
  logic [WIDTH_ACT_MEM-1:0]  mem_wdata_q;
  logic                      rd_s1, rd_s2;
  logic                      rd_oob_s1, rd_oob_s2;
  logic [WIDTH_ADDR_ACT-1:0] host_cnt_q;
  logic                      err_q;

  // Host loads are locked out while the core computes.
  assign elig = {core_wr_valid, core_rd_valid, spi_wr_valid & ~compute_active};

  rr_arbiter3 u_rr (
    .elig       (elig),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign spi_wr_ready  = grant[REQ_SPI];
  assign core_rd_ready = grant[REQ_CORE_RD];
  assign core_wr_ready = grant[REQ_CORE_WR];
  assign xfer          = |grant;
  assign sel_req       = onehot_to_req(grant);
  assign sel_we        = (sel_req != REQ_CORE_RD);

  always_comb begin
    sel_addr  = spi_wr_addr;
    sel_wdata = spi_wr_data;
    case (sel_req)
      REQ_CORE_RD: sel_addr = core_rd_addr;
      REQ_CORE_WR: begin
        sel_addr  = core_wr_addr;
        sel_wdata = core_wr_data;
      end
      default: ;
    endcase
  end

  // Extra MSB keeps the compare correct even when the depth fills the address space.
  assign sel_oob = BOUNDS_EN &&
                   ({1'b0, sel_addr} >= (WIDTH_ADDR_ACT + 1)'(DEPTH_ACT_MEM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= REQ_CORE_WR;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if (xfer) begin
        last_grant <= sel_req;
        if (!sel_oob) begin
          mem_en_q   <= 1'b1;
          mem_we_q   <= sel_we;
          mem_addr_q <= sel_addr;
          if (sel_we) mem_wdata_q <= sel_wdata;
        end
      end
    end
  end

  // Read tag pipeline matches the one-cycle memory latency behind the command register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      rd_oob_s1 <= 1'b0;
      rd_oob_s2 <= 1'b0;
    end else begin
      rd_s1     <= xfer && (sel_req == REQ_CORE_RD);
      rd_s2     <= rd_s1;
      rd_oob_s1 <= xfer && (sel_req == REQ_CORE_RD) && sel_oob;
      rd_oob_s2 <= rd_oob_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (xfer && (sel_req == REQ_SPI)) host_cnt_q <= host_cnt_q + WIDTH_ADDR_ACT'(1);
      if (xfer && sel_oob) err_q <= 1'b1;
    end
  end

  assign mem_en             = mem_en_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign core_rd_data_valid = rd_s2;
  assign core_rd_data       = rd_oob_s2 ? '0 : mem_rdata;
  assign host_wr_count      = host_cnt_q;
  assign err_oob            = err_q;

endmodule

// File: tb/tb_act_mem_arbiter.sv
// Bench for act_mem_arbiter: directed steps plus random traffic against a grant-order memory model.
module tb_act_mem_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 3000;

`ifdef ACT_ARB_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          compute_active;
  logic          spi_wr_valid, spi_wr_ready;
  logic [AW-1:0] spi_wr_addr;
  logic [DW-1:0] spi_wr_data;
  logic          core_rd_valid, core_rd_ready;
  logic [AW-1:0] core_rd_addr;
  logic [DW-1:0] core_rd_data;
  logic          core_rd_data_valid;
  logic          core_wr_valid, core_wr_ready;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] host_wr_count;
  logic          err_oob;

  always #5 clk = ~clk;

  act_mem_arbiter #(.WIDTH_ADDR_ACT(AW), .WIDTH_ACT_MEM(DW), .DEPTH_ACT_MEM(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .compute_active(compute_active),
    .spi_wr_valid(spi_wr_valid), .spi_wr_ready(spi_wr_ready),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready), .core_rd_addr(core_rd_addr),
    .core_rd_data(core_rd_data), .core_rd_data_valid(core_rd_data_valid),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .host_wr_count(host_wr_count), .err_oob(err_oob)
  );

  // Single-port synchronous SRAM with one-cycle read latency.
  logic [DW-1:0] tbmem [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata       <= tbmem[mem_addr];
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            m_last, m_count, obs_g;
  bit            m_err;
  bit            nxt_en, nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_wdata;
  logic [DW-1:0] ref_mem [0:4095];
  rd_exp_t       rq[$];
  int            exp_t1[6] = '{0, 1, 2, 0, 1, 2};
  int            exp_ca[6] = '{2, 1, 2, 1, 2, 1};
  bit            spi_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Next grant: first eligible requester after the last one, in order 0,1,2 cyclically.
  function automatic int model_pick(input bit [2:0] e, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (e[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = 2;
    m_count = 0;
    m_err   = 1'b0;
    nxt_en  = 1'b0;
    nxt_we  = 1'b0;
    rq.delete();
  endtask

  task automatic drive(input bit sv, input int sa, input int sd, input bit rv, input int ra,
                       input bit wv, input int wa, input int wd, input bit ca);
    spi_wr_valid   = sv;  spi_wr_addr  = AW'(sa); spi_wr_data  = DW'(sd);
    core_rd_valid  = rv;  core_rd_addr = AW'(ra);
    core_wr_valid  = wv;  core_wr_addr = AW'(wa); core_wr_data = DW'(wd);
    compute_active = ca;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_spi_rdy"}, spi_wr_ready, 0);
    chk({pfx, "_rd_rdy"}, core_rd_ready, 0);
    chk({pfx, "_wr_rdy"}, core_wr_ready, 0);
    chk({pfx, "_mem_en"}, mem_en, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_rd_vld"}, core_rd_data_valid, 0);
    chk({pfx, "_count"}, host_wr_count, 0);
    chk({pfx, "_err"}, err_oob, 0);
  endtask

  // One clock: check readys against the model, advance the model, then check registered outputs.
  task automatic cycle();
    bit [2:0]      e;
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            oob;
    rd_exp_t       r;
    #2;
    e     = {core_wr_valid, core_rd_valid, spi_wr_valid && !compute_active};
    g     = model_pick(e, m_last);
    obs_g = spi_wr_ready ? 0 : core_rd_ready ? 1 : core_wr_ready ? 2 : -1;
    chk("spi_wr_ready", spi_wr_ready, g == 0);
    chk("core_rd_ready", core_rd_ready, g == 1);
    chk("core_wr_ready", core_wr_ready, g == 2);
    nxt_en = 1'b0;
    nxt_we = 1'b0;
    if (g >= 0) begin
      m_last = g;
      a   = (g == 0) ? spi_wr_addr : (g == 1) ? core_rd_addr : core_wr_addr;
      d   = (g == 0) ? spi_wr_data : core_wr_data;
      oob = BCHK && (int'(a) >= DEPTH);
      if (oob) m_err = 1'b1;
      else begin
        nxt_en    = 1'b1;
        nxt_we    = (g != 1);
        nxt_addr  = a;
        nxt_wdata = d;
      end
      if (g == 1) begin
        r.due  = cyc + 2;
        r.data = oob ? '0 : ref_mem[a];
        rq.push_back(r);
      end else if (!oob) ref_mem[a] = d;
      if (g == 0) m_count = (m_count + 1) % 4096;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("mem_en", mem_en, nxt_en);
    chk("mem_we", mem_we, nxt_we);
    if (nxt_en) chk("mem_addr", mem_addr, nxt_addr);
    if (nxt_we) chk("mem_wdata", mem_wdata, nxt_wdata);
    chk("host_wr_count", host_wr_count, m_count);
    chk("err_oob", err_oob, m_err);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("rd_data_valid", core_rd_data_valid, 1);
      chk("rd_data", core_rd_data, rq[0].data);
      void'(rq.pop_front());
    end else begin
      chk("rd_data_valid", core_rd_data_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tbmem[i]   = DW'($urandom);
      ref_mem[i] = tbmem[i];
    end
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // All three requesters contend for six cycles.
    drive(1, 1, 8'h11, 1, 2, 1, 3, 8'h33, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t1_grant", obs_g, exp_t1[i]);
    end
    chk("t1_count", host_wr_count, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Write then read the same address.
    drive(1, 5, 8'hA5, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t2_we_write", mem_we, 1);
    chk("t2_addr_write", mem_addr, 5);
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cycle();
    chk("t2_we_read", mem_we, 0);
    chk("t2_en_read", mem_en, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t2_rd_vld", core_rd_data_valid, 1);
    chk("t2_rd_dat", core_rd_data, 8'hA5);
    cycle();

    // SPI blocked while computing; core requesters alternate.
    drive(1, 9, 8'h5A, 1, 9, 1, 10, 8'h77, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("ca_grant", obs_g, exp_ca[i]);
    end
    compute_active = 1'b0;
    spi_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (obs_g == 0) spi_seen = 1'b1;
    end
    chk("ca_spi_within3", spi_seen, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Random traffic over a small address window to provoke read-after-write hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 7) == 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

`ifdef ACT_ARB_BOUNDS_CHECK_EN
    drive(0, 0, 0, 0, 0, 1, 3000, 8'hEE, 0);
    cycle();
    chk("oob_wr_grant", obs_g, 2);
    chk("oob_mem_en", mem_en, 0);
    chk("oob_err_set", err_oob, 1);
    drive(0, 0, 0, 1, 3001, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("oob_err_sticky", err_oob, 1);
`endif

    // Reset one cycle after a read is accepted: the read must vanish.
    drive(0, 0, 0, 1, 7, 0, 0, 0, 0);
    cycle();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cyc++;
      chk("midrst_rd_vld", core_rd_data_valid, 0);
    end
    reset_n = 1'b1;
    drive(1, 20, 8'h01, 1, 20, 1, 21, 8'h02, 0);
    cycle();
    chk("post_rst_grant", obs_g, 0);

    // Counter wrap: 4095 host writes then one more.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4094; i++) begin
      spi_wr_addr = AW'(i);
      spi_wr_data = DW'($urandom);
      cycle();
    end
    chk("count_4095", host_wr_count, 4095);
    cycle();
    chk("count_wrap", host_wr_count, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/act_mem_arbiter.md
# act_mem_arbiter

Shares the single-port activation memory between three requesters: the SPI loader writing input activations, the core reading activations for the PE array, and the core writing back output activations. It sits between the SPI/loader logic and the compute core inside `top_design`, ahead of the activation memory macro. It grants one access per cycle using round-robin order and registers every memory command. It also returns read data to the core and counts host writes for status readback.

## Interface
- `WIDTH_ADDR_ACT`, 12, activation address width
- `WIDTH_ACT_MEM`, 8, activation word width
- `DEPTH_ACT_MEM`, 3000, number of valid words; addresses `>= DEPTH_ACT_MEM` are out of range

Ports:
- `clk` in 1: single clock for the whole block
- `reset_n` in 1: asynchronous active-low reset
- `compute_active` in 1: core is running; host access blocked while high
- `spi_wr_valid` in 1 / `spi_wr_ready` out 1 / `spi_wr_addr` in WIDTH_ADDR_ACT / `spi_wr_data` in WIDTH_ACT_MEM: host write channel
- `core_rd_valid` in 1 / `core_rd_ready` out 1 / `core_rd_addr` in WIDTH_ADDR_ACT: core read request
- `core_rd_data` out WIDTH_ACT_MEM / `core_rd_data_valid` out 1: read return
- `core_wr_valid` in 1 / `core_wr_ready` out 1 / `core_wr_addr` in WIDTH_ADDR_ACT / `core_wr_data` in WIDTH_ACT_MEM: core write-back channel
- `mem_en` out 1 / `mem_we` out 1 / `mem_addr` out WIDTH_ADDR_ACT / `mem_wdata` out WIDTH_ACT_MEM / `mem_rdata` in WIDTH_ACT_MEM: synchronous single-port memory with 1-cycle read latency
- `host_wr_count` out WIDTH_ADDR_ACT: number of host writes accepted since reset
- `err_oob` out 1: sticky out-of-range flag (only with `ACT_ARB_BOUNDS_CHECK_EN`)

## Operation
- **Eligibility.** A requester is eligible when its `*_valid` is high. The SPI requester is also gated by `!compute_active`.
- **Grant.** Exactly one eligible requester is granted per cycle. `*_ready` is combinational and is high only for the granted requester. A transfer happens when valid and ready are both high.
- **Round-robin order.** The order is SPI(0) → core_rd(1) → core_wr(2). The pointer `last_grant` is a 2-bit register, reset to 2, so SPI wins first. The search starts at `last_grant+1` and wraps from 2 to 0. The pointer updates only on a transfer.
- **No eligible requester.** All readys stay low and `last_grant` holds.
- **Memory command.** On a transfer, the next cycle drives `mem_en=1`, `mem_we` (1 for SPI or core_wr, 0 for core_rd), `mem_addr` and `mem_wdata` from registers. Otherwise `mem_en=0` and `mem_we=0`; `mem_addr` and `mem_wdata` hold their last values.
- **Read return.** A 2-stage valid pipeline tags reads. `core_rd_data_valid` is high 2 cycles after the transfer. `core_rd_data` is `mem_rdata` passed straight through and is qualified by the valid.
- **Host write counter.** `host_wr_count` increments on each SPI transfer and wraps at 2^WIDTH_ADDR_ACT.
- **Ordering.** Memory accesses happen in grant order. A write followed by a read of the same address in the next grant returns the new data.
- **`compute_active` rising.** SPI writes already accepted still complete. No new SPI grant is issued while `compute_active` is high.
- **Reset mid-operation.** All outputs go low, `last_grant` is set to 2, and in-flight reads are discarded with no `core_rd_data_valid`.

## Timing
- Reset values: all `*_ready` = 0 (combinational, with no valid asserted), `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `core_rd_data_valid` = 0, `host_wr_count` = 0, `err_oob` = 0.
- Accept-to-memory-command latency: 1 cycle. Read latency from accept to data valid: 2 cycles.
- Throughput is 1 transfer per cycle, with back-to-back grants allowed.
- Under full contention, each requester is granted at least once every 3 cycles.

## Configuration
- Macro `ACT_ARB_BOUNDS_CHECK_EN`.
- **Defined:** a request with `addr >= DEPTH_ACT_MEM` is still accepted (ready/valid completes) but issues no memory command (`mem_en` stays 0). `err_oob` sets the cycle after the transfer and is sticky until reset. A rejected read still returns `core_rd_data_valid` with `core_rd_data` forced to 0.
- **Undefined:** no check is made, the address is passed through unchanged, and `err_oob` is tied to 0.

## Structure
- Shared package `dfctrl_pkg`:
  - `act_req_e` enum: `REQ_SPI`=0, `REQ_CORE_RD`=1, `REQ_CORE_WR`=2
  - `ACT_MEM_HEADER` constant 2'b10
- Sub-module `rr_arbiter3`: takes an eligibility vector and `last_grant`, produces a one-hot grant. It is purely combinational; the pointer register lives in the parent.

## Test plan
- **Reset, then all three valid continuously for 6 cycles.** Grants run SPI, rd, wr, SPI, rd, wr. `host_wr_count` = 2.
- **SPI write addr 0x005 data 0xA5, then core read addr 0x005.** `mem_we` is 1 then 0. `core_rd_data_valid` is high 2 cycles after the read accept, with `core_rd_data` = 0xA5.
- **`compute_active`=1 with `spi_wr_valid` held high.** `spi_wr_ready` stays 0 and the core requests alternate. After `compute_active` drops, SPI is granted within 3 cycles.
- **Assert `reset_n`=0 one cycle after a core read accept.** No `core_rd_data_valid` appears; all outputs are 0; the first grant after reset goes to SPI.
- **With `ACT_ARB_BOUNDS_CHECK_EN`, core write to addr 3000.** The transfer is accepted, `mem_en` stays 0, and `err_oob`=1 from the next cycle and stays high.
- **1 SPI write with `host_wr_count` preset by 4095 prior writes.** The count wraps to 0.
